fetch_prefetch: RTL and testbench

//   Pipelined-core instruction fetch stage: owns the fetch PC, issues req/ack reads to instruction

---
 rtl/fetch_prefetch.sv | 169 ++++++++++++++++
 tb/tb_fetch_prefetch.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: owns the fetch PC, reads instruction memory and buffers words for decode.
// Latency: with a zero-wait memory the first valid_d comes 2 cycles after reset release or a redirect.
// Backpressure: stall_d holds the head entry. Requests stop while the FIFO has no room for another word.
//
// Ports:
//   clk, reset                 rising-edge clock; asynchronous active-high reset
//   imem_req/addr/ack/rdata    single-outstanding read port; req and addr are held until ack
//   stall_d                    decode cannot take the head entry this cycle
//   redirect/redirect_pc       taken branch or PC write; redirect_pc[1:0] are forced to zero
//   valid_d/instr_d/pc_d       head-of-FIFO entry, driven combinationally
//   pcplus8_d                  pc_d + 8 (R15 read value)
module fetch_prefetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall_d,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        valid_d,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic [31:0] pcplus8_d
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DROP} state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } entry_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_f_q, pc_f_d;
  logic [31:0]   addr_q, addr_d;
  logic          req_q, req_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  entry_t        mem_q [DEPTH];
  entry_t        mem_d [DEPTH];

  logic          ack;
  logic          pop;
  logic          push;
  logic [31:0]   target_pc;
  logic [CW-1:0] count_after_pop;
  entry_t        head;

  // Memory ack only means something while a request is actually out.
  assign ack       = imem_ack & req_q;
  assign target_pc = redirect_pc & 32'hFFFF_FFFC;
  // A redirect invalidates the head, so it can never be consumed that cycle.
  assign pop       = valid_d & ~stall_d & ~redirect;
  assign count_after_pop = count_q - CW'(pop);

  always_comb begin
    state_d = state_q;
    pc_f_d  = pc_f_q;
    addr_d  = addr_q;
    push    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (redirect) begin
          pc_f_d  = target_pc;
          addr_d  = target_pc;
          state_d = S_REQ;
        end else if (count_after_pop < DEPTH_C) begin
          addr_d  = pc_f_q;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (redirect) begin
          pc_f_d = target_pc;
          if (ack) begin
            // The returning word belongs to the old path: discard it and start the new path at once.
            addr_d = target_pc;
          end else begin
            // The in-flight request cannot be withdrawn, so its response must be discarded first.
            state_d = S_DROP;
          end
        end else if (ack) begin
          push   = 1'b1;
          pc_f_d = addr_q + 32'd4;
          if (count_after_pop + CW'(1) < DEPTH_C) begin
            addr_d = addr_q + 32'd4;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DROP: begin
        if (redirect) begin
          pc_f_d = target_pc;
        end
        if (ack) begin
          addr_d  = redirect ? target_pc : pc_f_q;
          state_d = S_REQ;
        end
      end
      default: state_d = S_IDLE;
    endcase
    req_d = (state_d != S_IDLE);
  end

  // The FIFO pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (redirect) begin
      wr_ptr_d = rd_ptr_q;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = '{instr: imem_rdata, pc: addr_q};
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      pc_f_q   <= RESET_PC;
      addr_q   <= '0;
      req_q    <= 1'b0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q  <= state_d;
      pc_f_q   <= pc_f_d;
      addr_q   <= addr_d;
      req_q    <= req_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

  assign head      = mem_q[rd_ptr_q];
  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign valid_d   = (count_q != '0);
  assign instr_d   = head.instr;
  assign pc_d      = head.pc;
  assign pcplus8_d = head.pc + 32'd8;

endmodule

// File: tb/tb_fetch_prefetch.sv
`timescale 1ns/1ps
module tb_fetch_prefetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall_d;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        valid_d;
  logic [31:0] instr_d;
  logic [31:0] pc_d;
  logic [31:0] pcplus8_d;

  int checks = 0;
  int errors = 0;
  int consumed = 0;

  // Memory model state: latency mode 0 = zero-wait, 1 = 3 wait cycles, 2 = random 0..3.
  int mode = 0;
  int age = 0;
  int lat_cur = 0;

  // Reference model: the in-order stream of PCs that decode should receive.
  logic [31:0] exp_q[$];
  logic [31:0] gen_pc;

  fetch_prefetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall_d(stall_d), .redirect(redirect), .redirect_pc(redirect_pc),
    .valid_d(valid_d), .instr_d(instr_d), .pc_d(pc_d), .pcplus8_d(pcplus8_d)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  assign imem_ack   = imem_req && (age >= lat_cur);
  assign imem_rdata = word_of(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_lat();
    case (mode)
      0:       return 0;
      1:       return 3;
      default: return int'($urandom_range(0, 3));
    endcase
  endfunction

  task automatic refill();
    while (exp_q.size() < 4) begin
      exp_q.push_back(gen_pc);
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic model_restart(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = pc & 32'hFFFF_FFFC;
    refill();
  endtask

  // Drive one cycle of inputs, update the model, then advance to 2ns after the next edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] tgt);
    stall_d     = st;
    redirect    = rd;
    redirect_pc = tgt;
    if (rd) model_restart(tgt);
    refill();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < 30; i++) begin
      if (valid_d) begin
        ok = 1;
        break;
      end
      step(0, 0, 32'h0);
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: valid_d got 0 expected 1 within 30 cycles", name);
    end
  endtask

  // Memory responder: one request at a time, new latency drawn at each request start.
  initial begin
    logic        s_req, s_fire;
    logic [31:0] s_addr;
    forever begin
      @(negedge clk);
      s_req  = imem_req;
      s_fire = imem_req && imem_ack;
      s_addr = imem_addr;
      @(posedge clk);
      #1;
      if (reset || !s_req || s_fire) begin
        age     = 0;
        lat_cur = pick_lat();
      end else begin
        age++;
        if (imem_req) chk("addr_stable", imem_addr, s_addr);
      end
    end
  end

  // Monitor: every instruction accepted by decode must be the next one of the model stream.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (!reset && valid_d && !stall_d && !redirect) begin
        consumed++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL stream: got pc %h expected none", pc_d);
        end else begin
          e = exp_q.pop_front();
          chk("stream_pc", pc_d, e);
          chk("stream_instr", instr_d, word_of(e));
          chk("stream_pcplus8", pcplus8_d, e + 32'd8);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation got stuck expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    int c0;
    bit found;
    reset = 1'b1;
    stall_d = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    model_restart(32'h0);

    repeat (2) @(posedge clk);
    #2;
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", {31'h0, valid_d}, 32'h0);
    chk("rst_instr", instr_d, 32'h0);
    chk("rst_pc", pc_d, 32'h0);
    chk("rst_pcplus8", pcplus8_d, 32'h8);
    reset = 1'b0;

    // First valid_d two cycles after reset release.
    n = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 32'h0);
      n++;
      if (valid_d) break;
    end
    chk("first_valid_latency", n, 2);

    // Zero-wait memory with no stall sustains one instruction per cycle.
    c0 = consumed;
    repeat (10) step(0, 0, 32'h0);
    chk("throughput", consumed - c0, 10);

    // Long stall: FIFO fills, requests stop, head frozen.
    c0 = consumed;
    repeat (5) step(1, 0, 32'h0);
    chk("stall_req", {31'h0, imem_req}, 32'h0);
    chk("stall_valid", {31'h0, valid_d}, 32'h1);
    chk("stall_head", pc_d, exp_q[0]);
    chk("stall_consumed", consumed - c0, 0);
    repeat (6) step(0, 0, 32'h0);

    // Redirect while the FIFO is full.
    repeat (3) step(1, 0, 32'h0);
    step(0, 1, 32'h0000_0300);
    chk("full_redir_empty", {31'h0, valid_d}, 32'h0);
    wait_valid("full_redir");
    chk("full_redir_pc", pc_d, 32'h0000_0300);
    repeat (3) step(0, 0, 32'h0);

    // Redirect in the same cycle as an ack, with decode stalled.
    found = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_ack) begin
        found = 1;
        break;
      end
      step(0, 0, 32'h0);
    end
    chk("ack_seen", {31'h0, found}, 32'h1);
    step(1, 1, 32'h0000_0203);
    chk("ack_redir_empty", {31'h0, valid_d}, 32'h0);
    wait_valid("ack_redir");
    chk("ack_redir_pc", pc_d, 32'h0000_0200);
    chk("ack_redir_instr", instr_d, word_of(32'h0000_0200));

    // PC wraps from the top of the address space to zero.
    step(0, 1, 32'hFFFF_FFFC);
    wait_valid("wrap");
    chk("wrap_pc", pc_d, 32'hFFFF_FFFC);
    chk("wrap_pcplus8", pcplus8_d, 32'h0000_0004);
    step(0, 0, 32'h0);
    chk("wrap_next_pc", pc_d, 32'h0000_0000);
    chk("wrap_next_pcplus8", pcplus8_d, 32'h0000_0008);

    // Slow memory: redirect while a request is waiting, stale word must be dropped.
    mode = 1;
    found = 0;
    for (int i = 0; i < 40; i++) begin
      if (imem_req && !imem_ack) begin
        found = 1;
        break;
      end
      step(0, 0, 32'h0);
    end
    chk("wait_seen", {31'h0, found}, 32'h1);
    step(0, 1, 32'h0000_0100);
    wait_valid("drop_redir");
    chk("drop_redir_pc", pc_d, 32'h0000_0100);
    chk("drop_redir_instr", instr_d, word_of(32'h0000_0100));
    repeat (8) step(0, 0, 32'h0);

    // Reset pulsed while a request is outstanding.
    found = 0;
    for (int i = 0; i < 30; i++) begin
      if (imem_req) begin
        found = 1;
        break;
      end
      step(0, 0, 32'h0);
    end
    chk("req_before_reset", {31'h0, found}, 32'h1);
    #1;
    reset = 1'b1;
    model_restart(32'h0);
    #1;
    chk("midrst_req", {31'h0, imem_req}, 32'h0);
    chk("midrst_valid", {31'h0, valid_d}, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    wait_valid("refetch");
    chk("refetch_pc", pc_d, 32'h0000_0000);

    // Randomised traffic: stalls, redirects and memory latency all vary.
    for (int i = 0; i < 600; i++) begin
      logic        st, rd;
      logic [31:0] tgt;
      mode = (i / 100) % 3;
      st = ($urandom_range(0, 9) < 3);
      rd = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else tgt = $urandom;
      step(st, rd, tgt);
    end

    mode = 0;
    c0 = consumed;
    repeat (20) step(0, 0, 32'h0);
    chk("drain_flow", {31'h0, (consumed - c0) >= 15}, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
